// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detector slice: the state encoding used
// by the serializer FSM and the default word width used by both the serializer
// and the detector bench.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        PAR   = 2'b10
    } seqState_e;

    localparam int SEQ_WIDTH = 8;

endpackage

// File: rtl/seq_parity.sv
// Even-parity generator for one serializer word: XOR reduction of all bits.
// Only built when SEQ_SERIALIZER_PARITY_EN is defined; the default build of the
// serializer has no parity cycle and does not need this module.
`ifdef SEQ_SERIALIZER_PARITY_EN
module seq_parity
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH
) (
    input  logic [WIDTH-1:0] i_word,
    output logic             o_parity
);

    // Parity is a pure function of the word; the serializer registers it.
    assign o_parity = ^i_word;

endmodule
`endif

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end for the bit-serial sequence detector.
// Words arrive over din/din_valid/din_ready and leave MSB-first on x, one bit
// per clock, qualified by x_valid. din_ready rises in the final bit cycle of a
// frame so that back-to-back words stream without idle cycles.
// Optional feature: define SEQ_SERIALIZER_PARITY_EN to append an even-parity
// bit after the LSB of every word (frame becomes WIDTH+1 cycles).
module seq_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    seqState_e        r_state;
    logic [WIDTH-1:0] r_shiftReg;
    logic [CW-1:0]    r_bitCnt;
    logic             r_x;
    logic             r_xValid;

    logic             w_lastBit;
    logic             w_xfer;

`ifdef SEQ_SERIALIZER_PARITY_EN
    logic             r_parity;
    logic             w_parity;

    seq_parity #(
        .WIDTH (WIDTH)
    ) u_parity (
        .i_word   (din),
        .o_parity (w_parity)
    );
`endif

    assign w_lastBit = (r_state == SHIFT) && (r_bitCnt == LAST_BIT);
    assign w_xfer    = din_valid && din_ready;
    assign x         = r_x;
    assign x_valid   = r_xValid;

    // Ready when idle or in the final cycle of the current frame.
    always_comb begin
        din_ready = 1'b0;
        case (r_state)
            IDLE:    din_ready = 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
            PAR:     din_ready = 1'b1;
`else
            SHIFT:   din_ready = w_lastBit;
`endif
            default: din_ready = 1'b0;
        endcase
    end

    // Serializer FSM: a transfer always (re)starts a frame at the MSB; the
    // shift register rotates so the next bit to send sits at WIDTH-2.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= IDLE;
            r_shiftReg <= '0;
            r_bitCnt   <= '0;
            r_x        <= 1'b0;
            r_xValid   <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else if (w_xfer) begin
            r_state    <= SHIFT;
            r_shiftReg <= din;
            r_bitCnt   <= '0;
            r_x        <= din[WIDTH-1];
            r_xValid   <= 1'b1;
`ifdef SEQ_SERIALIZER_PARITY_EN
            r_parity   <= w_parity;
`endif
        end else begin
            case (r_state)
                SHIFT: begin
                    if (!w_lastBit) begin
                        r_bitCnt   <= r_bitCnt + CW'(1);
                        r_shiftReg <= {r_shiftReg[WIDTH-2:0], r_shiftReg[WIDTH-1]};
                        r_x        <= r_shiftReg[WIDTH-2];
                        r_xValid   <= 1'b1;
                    end else begin
`ifdef SEQ_SERIALIZER_PARITY_EN
                        r_state  <= PAR;
                        r_x      <= r_parity;
                        r_xValid <= 1'b1;
`else
                        r_state  <= IDLE;
                        r_x      <= 1'b0;
                        r_xValid <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_x      <= 1'b0;
                    r_xValid <= 1'b0;
                end
            endcase
        end
    end

endmodule
